// File: rtl/bankr_wb_arbiter.sv
// Purpose : shares the register bank's single write port between writeback
//           requester A (ALU) and B (load path) with round-robin fairness.
// Latency : grant is combinational; the bank write (Rw/Dir/DIn) appears one
//           cycle after the accept edge and lasts exactly one cycle.
// Backpressure: a denied requester sees Gnt=0 and keeps Req/Dir/DIn held;
//           under contention it wins at most one cycle later.
//
// Ports:
//   Clk, Rst_n          clock and synchronous active-low reset
//   ReqA/DirA/DInA      requester A: request, destination register, data
//   ReqB/DirB/DInB      requester B: request, destination register, data
//   GntA/GntB           combinational accept strobes (mutually exclusive)
//   Rw/Dir/DIn          registered bank write enable, address, data
//   Pri                 round-robin pointer (0 = A preferred, 1 = B preferred)
//   ConflictCnt         saturating count of cycles with both requesting
module bankr_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          ReqA,
    input  logic [AW-1:0] DirA,
    input  logic [DW-1:0] DInA,
    input  logic          ReqB,
    input  logic [AW-1:0] DirB,
    input  logic [DW-1:0] DInB,
    output logic          GntA,
    output logic          GntB,
    output logic          Rw,
    output logic [AW-1:0] Dir,
    output logic [DW-1:0] DIn,
    output logic          Pri,
    output logic [CW-1:0] ConflictCnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          any_gnt;
    logic [AW-1:0] win_dir;
    logic [DW-1:0] win_din;

    // Under contention Pri picks the winner; a lone requester always wins.
    // Grants are masked during reset so nothing is consumed in that cycle.
    always_comb begin
        GntA    = Rst_n & ReqA & (~ReqB | ~Pri);
        GntB    = Rst_n & ReqB & (~ReqA |  Pri);
        any_gnt = GntA | GntB;
        win_dir = GntA ? DirA : DirB;
        win_din = GntA ? DInA : DInB;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Rw          <= 1'b0;
            Dir         <= '0;
            DIn         <= '0;
            Pri         <= 1'b0;
            ConflictCnt <= '0;
        end else begin
            if (any_gnt) begin
                Dir <= win_dir;
                DIn <= win_din;
                // Register 0 is hardwired: the write is consumed but not issued.
                Rw  <= (win_dir != '0);
                // The winner becomes the non-preferred side for next time.
                Pri <= GntA;
            end else begin
                Rw  <= 1'b0;
            end
            if (ReqA && ReqB && (ConflictCnt != CNT_MAX)) begin
                ConflictCnt <= ConflictCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bankr_wb_arbiter.sv
module tb_bankr_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          ReqA = 1'b0, ReqB = 1'b0;
    logic [AW-1:0] DirA = '0, DirB = '0;
    logic [DW-1:0] DInA = '0, DInB = '0;

    logic          GntA, GntB, Rw, Pri;
    logic [AW-1:0] Dir;
    logic [DW-1:0] DIn;
    logic [7:0]    ConflictCnt;

    logic          s_GntA, s_GntB, s_Rw, s_Pri;
    logic [AW-1:0] s_Dir;
    logic [DW-1:0] s_DIn;
    logic [1:0]    s_Cnt;

    always #5 Clk = ~Clk;

    bankr_wb_arbiter #(.AW(AW), .DW(DW), .CW(8)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA(ReqA), .DirA(DirA), .DInA(DInA),
        .ReqB(ReqB), .DirB(DirB), .DInB(DInB),
        .GntA(GntA), .GntB(GntB),
        .Rw(Rw), .Dir(Dir), .DIn(DIn),
        .Pri(Pri), .ConflictCnt(ConflictCnt)
    );

    // Narrow-counter copy for the saturation case, driven by the same inputs.
    bankr_wb_arbiter #(.AW(AW), .DW(DW), .CW(2)) u_sat (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA(ReqA), .DirA(DirA), .DInA(DInA),
        .ReqB(ReqB), .DirB(DirB), .DInB(DInB),
        .GntA(s_GntA), .GntB(s_GntB),
        .Rw(s_Rw), .Dir(s_Dir), .DIn(s_DIn),
        .Pri(s_Pri), .ConflictCnt(s_Cnt)
    );

    typedef struct {
        logic          rst;
        logic          ra;
        logic [AW-1:0] da;
        logic [DW-1:0] xa;
        logic          rb;
        logic [AW-1:0] db;
        logic [DW-1:0] xb;
        logic          ga;
        logic          gb;
    } vec_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] dir;
        logic [DW-1:0] din;
    } wr_t;

    int checks = 0;
    int errors = 0;

    wr_t           sbq[$];
    wr_t           m_last = '{1'b0, '0, '0};
    logic          m_pri  = 1'b0;
    logic [7:0]    m_cnt  = '0;
    logic [1:0]    m_cnt2 = '0;
    logic [DW-1:0] bank [0:31];

    vec_t tab [0:23];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: grants checked mid-cycle, registered outputs
    // checked #1 after the edge against the scoreboard entry pushed here.
    task automatic run(input vec_t v, input bit use_tab);
        logic mga, mgb;
        wr_t  e, got;
        Rst_n = v.rst;
        ReqA = v.ra; DirA = v.da; DInA = v.xa;
        ReqB = v.rb; DirB = v.db; DInB = v.xb;
        #1;
        mga = v.rst & v.ra & (!v.rb | (m_pri == 1'b0));
        mgb = v.rst & v.rb & (!v.ra | (m_pri == 1'b1));
        if (use_tab) begin
            chk("GntA", 64'(GntA), 64'(v.ga));
            chk("GntB", 64'(GntB), 64'(v.gb));
        end else begin
            chk("GntA_model", 64'(GntA), 64'(mga));
            chk("GntB_model", 64'(GntB), 64'(mgb));
        end
        chk("gnt_onehot", 64'(GntA & GntB), 64'd0);

        if (!v.rst) begin
            e = '{1'b0, '0, '0};
            m_pri = 1'b0; m_cnt = '0; m_cnt2 = '0;
        end else begin
            if (mga)      e = '{(v.da != 0), v.da, v.xa};
            else if (mgb) e = '{(v.db != 0), v.db, v.xb};
            else          e = '{1'b0, m_last.dir, m_last.din};
            if (mga || mgb) m_pri = mga;
            if (v.ra && v.rb) begin
                if (m_cnt != 8'hFF)  m_cnt  = m_cnt + 1'b1;
                if (m_cnt2 != 2'h3) m_cnt2 = m_cnt2 + 1'b1;
            end
        end
        m_last = e;
        sbq.push_back(e);

        @(posedge Clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sbq.pop_front();
            chk("Rw",  64'(Rw),  64'(got.rw));
            chk("Dir", 64'(Dir), 64'(got.dir));
            chk("DIn", 64'(DIn), 64'(got.din));
        end
        chk("Pri",          64'(Pri),         64'(m_pri));
        chk("ConflictCnt",  64'(ConflictCnt), 64'(m_cnt));
        chk("ConflictCnt2", 64'(s_Cnt),       64'(m_cnt2));
        if (Rw === 1'b1) bank[Dir] = DIn;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) bank[i] = '0;

        //          rst ra da  xa            rb db  xb           ga gb
        // reset held with both requesting
        tab[0]  = '{0, 1, 1, 32'hA1,       1, 2, 32'hB1,       0, 0};
        tab[1]  = '{0, 1, 1, 32'hA1,       1, 2, 32'hB1,       0, 0};
        // release: A wins same cycle, B keeps holding then wins
        tab[2]  = '{1, 1, 1, 32'hA1,       1, 2, 32'hB1,       1, 0};
        tab[3]  = '{1, 0, 0, 32'h0,        1, 2, 32'hB1,       0, 1};
        // single requester A, then idle
        tab[4]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0};
        tab[5]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        // register-0 drop via B
        tab[6]  = '{1, 0, 0, 32'h0,        1, 0, 32'h1234,     0, 1};
        // reset, then 4 cycles of contention A,B,A,B
        tab[7]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        tab[8]  = '{1, 1, 3, 32'hA0,       1, 4, 32'hB0,       1, 0};
        tab[9]  = '{1, 1, 3, 32'hA1,       1, 4, 32'hB0,       0, 1};
        tab[10] = '{1, 1, 3, 32'hA1,       1, 4, 32'hB1,       1, 0};
        tab[11] = '{1, 1, 3, 32'hA2,       1, 4, 32'hB1,       0, 1};
        // same-address collision on reg 7
        tab[12] = '{1, 1, 7, 32'h11,       1, 7, 32'h22,       1, 0};
        tab[13] = '{1, 0, 0, 32'h0,        1, 7, 32'h22,       0, 1};
        // reset, then 6 cycles of contention for counter saturation
        tab[14] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0};
        tab[15] = '{1, 1, 1, 32'hC0,       1, 2, 32'hD0,       1, 0};
        tab[16] = '{1, 1, 1, 32'hC1,       1, 2, 32'hD0,       0, 1};
        tab[17] = '{1, 1, 1, 32'hC1,       1, 2, 32'hD1,       1, 0};
        tab[18] = '{1, 1, 1, 32'hC2,       1, 2, 32'hD1,       0, 1};
        tab[19] = '{1, 1, 1, 32'hC2,       1, 2, 32'hD2,       1, 0};
        tab[20] = '{1, 1, 1, 32'hC3,       1, 2, 32'hD2,       0, 1};
        // grant, then reset in the following cycle while Rw=1 is pending
        tab[21] = '{1, 1, 9, 32'hE0,       0, 0, 32'h0,        1, 0};
        tab[22] = '{0, 1, 9, 32'hE1,       1, 2, 32'hF0,       0, 0};
        tab[23] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0};

        @(posedge Clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            run(tab[i], 1'b1);
            if (i == 1) begin
                chk("rst_Rw",  64'(Rw),          64'd0);
                chk("rst_Pri", 64'(Pri),         64'd0);
                chk("rst_Cnt", 64'(ConflictCnt), 64'd0);
            end
            if (i == 11) chk("contention_cnt", 64'(ConflictCnt), 64'd4);
            if (i == 20) chk("sat_cnt", 64'(s_Cnt), 64'd3);
            if (i == 22) begin
                chk("midrst_Rw",  64'(Rw),          64'd0);
                chk("midrst_Cnt", 64'(ConflictCnt), 64'd0);
            end
        end
        chk("reg7_final", 64'(bank[7]), 64'h22);

        // Loser drops its request without ever being granted: pointer and
        // output register must not react to it.
        v = '{1, 1, 6, 32'h66, 1, 8, 32'h88, 0, 0};
        run(v, 1'b0);
        v = '{1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0};
        run(v, 1'b0);
        chk("drop_Pri_held", 64'(Pri), 64'd1);
        run(v, 1'b0);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 200; i++) begin
            v.rst = ($urandom_range(0, 19) != 0);
            v.ra  = $urandom_range(0, 1);
            v.da  = AW'($urandom_range(0, 31));
            v.xa  = $urandom;
            v.rb  = $urandom_range(0, 1);
            v.db  = AW'($urandom_range(0, 31));
            v.xb  = $urandom;
            v.ga  = 1'b0;
            v.gb  = 1'b0;
            run(v, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
